snake_body_tracker: RTL and testbench

- Owns the snake's segment list, advances it one grid cell per move tick and detects collisions.
- Produces the goodColl and body signals that the apple generator consumes, so it is the producer end of that interface.
- Also answers a per-pixel "is snake here" query for the display path.
- Sits between the input/direction logic and the apple generator / renderer.

---
 rtl/snake_pkg.sv | 56 +++++
 rtl/snake_body_tracker_if.sv | 14 +
 rtl/snake_occupancy.sv | 23 ++
 rtl/snake_body_tracker.sv | 147 ++++++++++++++
 tb/tb_snake_body_tracker.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared grid dimensions, direction/state encodings and segment layout
// for the snake body tracker and its helpers.
package snake_pkg;

  localparam int GRID_W   = 14;
  localparam int GRID_H   = 10;
  localparam int MAX_LEN  = 50;
  localparam int INIT_LEN = 4;

  localparam logic [5:0] MAX_LEN_W  = 6'(MAX_LEN);
  localparam logic [5:0] INIT_LEN_W = 6'(INIT_LEN);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } seg_t;

  typedef logic [MAX_LEN-1:0][7:0] body_t;

  // Vertical snake in column 4, head at row 8, tail at row 5.
  localparam body_t INIT_BODY = {{((MAX_LEN - INIT_LEN) * 8){1'b0}},
                                 8'h45, 8'h46, 8'h47, 8'h48};

  // UP/DOWN and LEFT/RIGHT differ only in bit 0.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return ((a ^ b) == 2'b01);
  endfunction

  // Out-of-range moves wrap in 4 bits and land at or above the grid limit.
  function automatic seg_t step(input seg_t h, input dir_t d);
    seg_t n;
    n = h;
    case (d)
      DIR_UP:    n.y = h.y - 4'd1;
      DIR_DOWN:  n.y = h.y + 4'd1;
      DIR_LEFT:  n.x = h.x - 4'd1;
      DIR_RIGHT: n.x = h.x + 4'd1;
      default:   n = h;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/snake_body_tracker_if.sv
// Link between the body tracker (producer of body/goodColl) and the apple
// generator (producer of the apple cell).
interface snake_body_tracker_if;
  import snake_pkg::*;

  logic [MAX_LEN-1:0][7:0] body;
  logic                    goodColl;
  logic [3:0]              apple_x;
  logic [3:0]              apple_y;

  modport master (output body, goodColl, input apple_x, apple_y);
  modport slave  (input body, goodColl, output apple_x, apple_y);

endinterface

// File: rtl/snake_occupancy.sv
// Reports whether a cell matches any body slot below a given index limit.
module snake_occupancy
  import snake_pkg::*;
(
  input  logic [7:0]               point,
  input  logic [MAX_LEN-1:0][7:0]  body,
  input  logic [5:0]               limit,
  output logic                     hit
);

  // Parallel compare of every slot, masked by the active limit.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((6'(i) < limit) && (body[i] == point)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/snake_body_tracker.sv
// Snake segment list: moves one cell per tick in RUN, grows on the apple,
// and latches death on wall or self collision.
module snake_body_tracker
  import snake_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_reset,
  input  logic                        start,
  input  logic                        tick,
  input  logic [1:0]                  dir,
  input  logic [3:0]                  x,
  input  logic [3:0]                  y,
  output logic [5:0]                  length,
  output logic                        dead,
  output logic                        snake,
  snake_body_tracker_if.master        bus
);

  state_t     state_r, state_s;
  dir_t       dir_r, dir_s;
  body_t      body_r, body_s;
  logic [5:0] length_r, length_s;
  logic       good_r, good_s;
  logic       dead_r, dead_s;

  dir_t       dir_req_s, dir_eff_s;
  seg_t       head_s, nh_s;
  logic       grow_s, wall_s, self_hit_s;
  logic [5:0] self_limit_s;

  // Candidate move; the vacating tail only counts as body when growing.
  always_comb begin
    dir_req_s = dir_t'(dir);
    if (is_opposite(dir_req_s, dir_r)) begin
      dir_eff_s = dir_r;
    end else begin
      dir_eff_s = dir_req_s;
    end
    head_s = seg_t'(body_r[0]);
    nh_s   = step(head_s, dir_eff_s);
    grow_s = (nh_s == seg_t'({bus.apple_x, bus.apple_y}));
    wall_s = (nh_s.x >= 4'(GRID_W)) || (nh_s.y >= 4'(GRID_H));
    if (grow_s) begin
      self_limit_s = length_r;
    end else begin
      self_limit_s = length_r - 6'd1;
    end
  end

  snake_occupancy u_self_occ (
    .point (nh_s),
    .body  (body_r),
    .limit (self_limit_s),
    .hit   (self_hit_s)
  );

  snake_occupancy u_pixel_occ (
    .point ({x, y}),
    .body  (body_r),
    .limit (length_r),
    .hit   (snake)
  );

  // Next-state and move logic.
  always_comb begin
    state_s  = state_r;
    dir_s    = dir_r;
    body_s   = body_r;
    length_s = length_r;
    good_s   = 1'b0;
    dead_s   = dead_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tick) begin
          dir_s = dir_eff_s;
          if (wall_s || self_hit_s) begin
            state_s = ST_DEAD;
            dead_s  = 1'b1;
          end else begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
              body_s[i] = body_r[i-1];
            end
            body_s[0] = nh_s;
            if (grow_s) begin
              good_s = 1'b1;
              if (length_r != MAX_LEN_W) begin
                length_s = length_r + 6'd1;
              end else begin
                length_s = length_r;
              end
            end else begin
              // Old tail has shifted into slot[length]; clear it.
              for (int i = 0; i < MAX_LEN; i++) begin
                if (6'(i) == length_r) begin
                  body_s[i] = 8'h00;
                end else begin
                  body_s[i] = body_s[i];
                end
              end
            end
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DEAD: begin
        state_s = ST_DEAD;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous restart.
  always_ff @(posedge clk) begin
    if (reset || s_reset) begin
      state_r  <= ST_IDLE;
      dir_r    <= DIR_DOWN;
      body_r   <= INIT_BODY;
      length_r <= INIT_LEN_W;
      good_r   <= 1'b0;
      dead_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      dir_r    <= dir_s;
      body_r   <= body_s;
      length_r <= length_s;
      good_r   <= good_s;
      dead_r   <= dead_s;
    end
  end

  assign bus.body     = body_r;
  assign bus.goodColl = good_r;
  assign length       = length_r;
  assign dead         = dead_r;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed self-checking bench for snake_body_tracker.
module tb_snake_body_tracker;

  logic       clk = 1'b0;
  logic       reset, s_reset, start, tick;
  logic [1:0] dir;
  logic [3:0] x, y;
  logic [5:0] length;
  logic       dead, snake;
  int         checks = 0;
  int         errors = 0;

  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  snake_body_tracker_if bus_if ();

  snake_body_tracker dut (
    .clk     (clk),
    .reset   (reset),
    .s_reset (s_reset),
    .start   (start),
    .tick    (tick),
    .dir     (dir),
    .x       (x),
    .y       (y),
    .length  (length),
    .dead    (dead),
    .snake   (snake),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk_body4(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    chk({tag, "_b0"}, bus_if.body[0], b0);
    chk({tag, "_b1"}, bus_if.body[1], b1);
    chk({tag, "_b2"}, bus_if.body[2], b2);
    chk({tag, "_b3"}, bus_if.body[3], b3);
  endtask

  task automatic chk_flags(input string tag, input logic [7:0] len, input logic d, input logic g);
    chk({tag, "_len"}, 8'(length), len);
    chk({tag, "_dead"}, 8'(dead), 8'(d));
    chk({tag, "_good"}, 8'(bus_if.goodColl), 8'(g));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mv(input logic [1:0] d);
    dir  = d;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic set_apple(input logic [3:0] ax, input logic [3:0] ay);
    bus_if.apple_x = ax;
    bus_if.apple_y = ay;
  endtask

  task automatic query(input string tag, input logic [3:0] qx, input logic [3:0] qy, input logic exp);
    x = qx;
    y = qy;
    #1;
    chk(tag, 8'(snake), 8'(exp));
  endtask

  initial begin
    reset = 1'b1; s_reset = 1'b0; start = 1'b0; tick = 1'b0;
    dir = DOWN; x = 4'd0; y = 4'd0;
    set_apple(4'd13, 4'd0);
    cyc();
    cyc();
    reset = 1'b0;

    // Reset image and pixel query, including the (0,0) alias case
    chk_body4("rst", 8'h48, 8'h47, 8'h46, 8'h45);
    chk("rst_b4", bus_if.body[4], 8'h00);
    chk("rst_b49", bus_if.body[49], 8'h00);
    chk_flags("rst", 8'd4, 1'b0, 1'b0);
    query("q46", 4'd4, 4'd6, 1'b1);
    query("q00", 4'd0, 4'd0, 1'b0);
    query("q45", 4'd4, 4'd5, 1'b1);
    query("q44", 4'd4, 4'd4, 1'b0);

    // Plain move down
    start = 1'b1; cyc(); start = 1'b0;
    set_apple(4'd5, 4'd8);
    mv(DOWN);
    chk_body4("mv", 8'h49, 8'h48, 8'h47, 8'h46);
    chk("mv_b4", bus_if.body[4], 8'h00);
    chk_flags("mv", 8'd4, 1'b0, 1'b0);
    query("q45_vacated", 4'd4, 4'd5, 1'b0);

    // start+tick together in IDLE: enters RUN without moving, then grows
    reset = 1'b1; cyc(); reset = 1'b0;
    dir = DOWN; start = 1'b1; tick = 1'b1;
    cyc();
    start = 1'b0; tick = 1'b0;
    chk("st_tick_head", bus_if.body[0], 8'h48);
    set_apple(4'd4, 4'd9);
    mv(DOWN);
    chk_body4("grow", 8'h49, 8'h48, 8'h47, 8'h46);
    chk("grow_b4", bus_if.body[4], 8'h45);
    chk_flags("grow", 8'd5, 1'b0, 1'b1);
    cyc();
    chk("grow_pulse_end", 8'(bus_if.goodColl), 8'h00);

    // Reverse request ignored, then bottom wall
    restart();
    set_apple(4'd13, 4'd0);
    mv(UP);
    chk("rev_head", bus_if.body[0], 8'h49);
    chk_flags("rev", 8'd4, 1'b0, 1'b0);
    mv(DOWN);
    chk_flags("wall_y", 8'd4, 1'b1, 1'b0);
    chk("wall_y_head", bus_if.body[0], 8'h49);
    mv(DOWN);
    chk("dead_frozen_b0", bus_if.body[0], 8'h49);
    chk("dead_frozen_b1", bus_if.body[1], 8'h48);
    start = 1'b1; cyc(); start = 1'b0;
    chk("dead_sticky", 8'(dead), 8'h01);

    // Left wall via x underflow
    restart();
    mv(LEFT); mv(LEFT); mv(LEFT); mv(LEFT);
    chk_body4("left", 8'h08, 8'h18, 8'h28, 8'h38);
    chk("left_alive", 8'(dead), 8'h00);
    mv(LEFT);
    chk("wall_x_dead", 8'(dead), 8'h01);
    chk("wall_x_head", bus_if.body[0], 8'h08);

    // Tail chase into the vacating cell is legal
    restart();
    mv(RIGHT); mv(UP); mv(LEFT);
    chk_body4("chase", 8'h47, 8'h57, 8'h58, 8'h48);
    chk("chase_b4", bus_if.body[4], 8'h00);
    chk_flags("chase", 8'd4, 1'b0, 1'b0);

    // Same loop onto an apple sitting in the tail cell is fatal
    restart();
    set_apple(4'd4, 4'd7);
    mv(RIGHT); mv(UP); mv(LEFT);
    chk_body4("grow_tail", 8'h57, 8'h58, 8'h48, 8'h47);
    chk_flags("grow_tail", 8'd4, 1'b1, 1'b0);

    // Self hit on slot 3 of a length-5 snake
    restart();
    set_apple(4'd5, 4'd8);
    mv(RIGHT);
    chk_flags("self_grow", 8'd5, 1'b0, 1'b1);
    set_apple(4'd13, 4'd0);
    mv(UP);
    chk("self_up_head", bus_if.body[0], 8'h57);
    chk("self_up_good", 8'(bus_if.goodColl), 8'h00);
    chk("self_up_b4", bus_if.body[4], 8'h46);
    chk("self_up_b5", bus_if.body[5], 8'h00);
    mv(LEFT);
    chk_flags("self_hit", 8'd5, 1'b1, 1'b0);
    chk("self_hit_b0", bus_if.body[0], 8'h57);
    chk("self_hit_b3", bus_if.body[3], 8'h47);

    // Grow to 7, then s_reset mid-run
    restart();
    set_apple(4'd4, 4'd9); mv(DOWN); cyc();
    set_apple(4'd5, 4'd9); mv(RIGHT); cyc();
    set_apple(4'd6, 4'd9); mv(RIGHT);
    chk("len7", 8'(length), 8'd7);
    chk("len7_b0", bus_if.body[0], 8'h69);
    chk("len7_b6", bus_if.body[6], 8'h45);
    set_apple(4'd13, 4'd0);
    s_reset = 1'b1; cyc(); s_reset = 1'b0;
    chk_body4("srst", 8'h48, 8'h47, 8'h46, 8'h45);
    chk("srst_b6", bus_if.body[6], 8'h00);
    chk_flags("srst", 8'd4, 1'b0, 1'b0);
    mv(DOWN);
    chk("srst_idle_head", bus_if.body[0], 8'h48);

    // s_reset beats start in the same cycle
    start = 1'b1;
    mv(DOWN);
    start = 1'b0;
    s_reset = 1'b1; start = 1'b1; cyc(); s_reset = 1'b0; start = 1'b0;
    mv(DOWN);
    chk("srst_over_start", bus_if.body[0], 8'h48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
